// File: rtl/xadc_drp_reader_pkg.sv
// Shared definitions for the XADC DRP sample reader.
// Holds DRP widths, the two XADC auxiliary channel register addresses,
// the reader FSM state type and the sample-pair payload layout.
package xadc_drp_package;

    localparam int unsigned XADC_DRP_DATA_WIDTH      = 16;
    localparam int unsigned XADC_DRP_AXIS_ADDR_WIDTH = 7;

    // vaux4 carries shunt current, vaux12 carries bus voltage
    localparam logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] XADC_DRP_ADDR_CURRENT_CHANNEL = 7'h14;
    localparam logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] XADC_DRP_ADDR_VOLTAGE_CHANNEL = 7'h1C;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_CURRENT = 2'd1,
        ST_WAIT_VOLTAGE = 2'd2,
        ST_PRESENT      = 2'd3
    } xadc_drp_reader_state_t;

    // One stream beat: raw DRP words, voltage in the upper half
    typedef struct packed {
        logic [XADC_DRP_DATA_WIDTH-1:0] voltage;
        logic [XADC_DRP_DATA_WIDTH-1:0] current;
    } xadc_sample_t;

endpackage

// File: rtl/xadc_drp_reader_if.sv
// DRP port plus sample stream bundle between the reader and its neighbours.
// master: the reader (drives daddr/den/dwe/di and the sample stream).
// slave : XADC wizard/BFM together with the downstream sample sink.
interface xadc_drp_reader_if;
    import xadc_drp_package::*;

    logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] daddr_out;
    logic                                den_out;
    logic                                dwe_out;
    logic [XADC_DRP_DATA_WIDTH-1:0]      di_out;
    logic [XADC_DRP_DATA_WIDTH-1:0]      do_in;
    logic                                drdy_in;
    logic                                eos_in;
    logic [2*XADC_DRP_DATA_WIDTH-1:0]    sample_tdata_out;
    logic                                sample_tvalid_out;
    logic                                sample_tready_in;

    modport master (
        output daddr_out, den_out, dwe_out, di_out, sample_tdata_out, sample_tvalid_out,
        input  do_in, drdy_in, eos_in, sample_tready_in
    );

    modport slave (
        input  daddr_out, den_out, dwe_out, di_out, sample_tdata_out, sample_tvalid_out,
        output do_in, drdy_in, eos_in, sample_tready_in
    );

endinterface

// File: rtl/xadc_drp_reader_txn.sv
// Single DRP read transaction engine: one den pulse, then wait for drdy or timeout.
// Ports: clk_i/rst_n_i clock and async active-low reset; start_i/addr_i launch a read;
// daddr_o/den_o registered DRP request; do_i/drdy_i DRP response;
// data_c_o/done_c_o/timeout_c_o combinational completion, valid for the cycle they are high.
module xadc_drp_read_txn
    import xadc_drp_package::*;
#(
    parameter int unsigned DRDY_TIMEOUT = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                start_i,
    input  logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] addr_i,
    output logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] daddr_o,
    output logic                                den_o,
    input  logic [XADC_DRP_DATA_WIDTH-1:0]      do_i,
    input  logic                                drdy_i,
    output logic [XADC_DRP_DATA_WIDTH-1:0]      data_c_o,
    output logic                                done_c_o,
    output logic                                timeout_c_o
);

    localparam int unsigned AW    = XADC_DRP_AXIS_ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(DRDY_TIMEOUT + 1);

    logic [AW-1:0]    daddr_q, daddr_d;
    logic             den_q, den_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_c;

    // cnt_q counts edges since den; drdy is still honoured on the last allowed edge
    assign expired_c   = busy_q && !drdy_i && (cnt_q == CNT_W'(DRDY_TIMEOUT - 1));
    assign done_c_o    = busy_q && drdy_i;
    assign timeout_c_o = expired_c;
    assign data_c_o    = do_i;
    assign daddr_o     = daddr_q;
    assign den_o       = den_q;

    // Launch wins over completion so a back-to-back read can start on the drdy edge
    always_comb begin
        den_d   = 1'b0;
        daddr_d = daddr_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            den_d   = 1'b1;
            daddr_d = addr_i;
            busy_d  = 1'b1;
            cnt_d   = '0;
        end else if (busy_q) begin
            if (drdy_i || expired_c) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            daddr_q <= '0;
            den_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            daddr_q <= daddr_d;
            den_q   <= den_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/xadc_drp_reader.sv
// XADC DRP initiator: on each end-of-sequence pulse reads vaux4 (current) then
// vaux12 (voltage) and presents {voltage, current} as one valid/ready beat.
// Ports: dclk_in sole clock; reset_n_in async active-low reset; drp bundle carries
// the DRP request/response and the sample stream; dropped_count_out saturating
// count of EOS pulses seen while busy; timeout_out sticky drdy-timeout flag.
// Optional: define XADC_DRP_READER_SEQ_TAG_EN to add sample_seq_out, an 8-bit
// per-beat sequence number that advances only on accepted beats.
module xadc_drp_reader
    import xadc_drp_package::*;
#(
    parameter int unsigned DRDY_TIMEOUT     = 64,
    parameter int unsigned DROP_COUNT_WIDTH = 16
) (
    input  logic                        dclk_in,
    input  logic                        reset_n_in,
    xadc_drp_reader_if.master           drp,
    output logic [DROP_COUNT_WIDTH-1:0] dropped_count_out,
    output logic                        timeout_out
`ifdef XADC_DRP_READER_SEQ_TAG_EN
    ,
    output logic [7:0]                  sample_seq_out
`endif
);

    localparam int unsigned DW = XADC_DRP_DATA_WIDTH;
    localparam int unsigned AW = XADC_DRP_AXIS_ADDR_WIDTH;

    xadc_drp_reader_state_t      state_q, state_d;
    logic [DW-1:0]               cur_q, cur_d;
    xadc_sample_t                tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_q, drop_d;
    logic                        timeout_q, timeout_d;
`ifdef XADC_DRP_READER_SEQ_TAG_EN
    logic [7:0]                  seq_q, seq_d;
`endif

    logic          txn_start_c;
    logic [AW-1:0] txn_addr_c;
    logic [AW-1:0] txn_daddr;
    logic          txn_den;
    logic [DW-1:0] txn_data_c;
    logic          txn_done_c;
    logic          txn_timeout_c;

    // Shared read engine, reused for both channels
    xadc_drp_read_txn #(
        .DRDY_TIMEOUT (DRDY_TIMEOUT)
    ) u_txn (
        .clk_i       (dclk_in),
        .rst_n_i     (reset_n_in),
        .start_i     (txn_start_c),
        .addr_i      (txn_addr_c),
        .daddr_o     (txn_daddr),
        .den_o       (txn_den),
        .do_i        (drp.do_in),
        .drdy_i      (drp.drdy_in),
        .data_c_o    (txn_data_c),
        .done_c_o    (txn_done_c),
        .timeout_c_o (txn_timeout_c)
    );

    // Sequencing FSM and drop accounting
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        drop_d      = drop_q;
        timeout_d   = timeout_q;
        txn_start_c = 1'b0;
        txn_addr_c  = XADC_DRP_ADDR_CURRENT_CHANNEL;
`ifdef XADC_DRP_READER_SEQ_TAG_EN
        seq_d       = seq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (drp.eos_in) begin
                    txn_start_c = 1'b1;
                    state_d     = ST_WAIT_CURRENT;
                end
            end
            ST_WAIT_CURRENT: begin
                if (txn_done_c) begin
                    cur_d       = txn_data_c;
                    txn_start_c = 1'b1;
                    txn_addr_c  = XADC_DRP_ADDR_VOLTAGE_CHANNEL;
                    state_d     = ST_WAIT_VOLTAGE;
                end else if (txn_timeout_c) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_VOLTAGE: begin
                if (txn_done_c) begin
                    tdata_d.voltage = txn_data_c;
                    tdata_d.current = cur_q;
                    tvalid_d        = 1'b1;
                    state_d         = ST_PRESENT;
                end else if (txn_timeout_c) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (drp.sample_tready_in) begin
                    tvalid_d = 1'b0;
                    state_d  = ST_IDLE;
`ifdef XADC_DRP_READER_SEQ_TAG_EN
                    seq_d    = seq_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Any EOS outside IDLE (including the handshake cycle) is discarded
        if (drp.eos_in && (state_q != ST_IDLE) && !(&drop_q)) begin
            drop_d = drop_q + DROP_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge dclk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            drop_q    <= '0;
            timeout_q <= 1'b0;
`ifdef XADC_DRP_READER_SEQ_TAG_EN
            seq_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
`ifdef XADC_DRP_READER_SEQ_TAG_EN
            seq_q     <= seq_d;
`endif
        end
    end

    assign drp.daddr_out         = txn_daddr;
    assign drp.den_out           = txn_den;
    assign drp.dwe_out           = 1'b0;
    assign drp.di_out            = '0;
    assign drp.sample_tdata_out  = tdata_q;
    assign drp.sample_tvalid_out = tvalid_q;
    assign dropped_count_out     = drop_q;
    assign timeout_out           = timeout_q;
`ifdef XADC_DRP_READER_SEQ_TAG_EN
    assign sample_seq_out        = seq_q;
`endif

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Bench for xadc_drp_reader: a negedge XADC responder returns drdy three cycles
// after each den; expected DRP addresses and sample beats go into scoreboard
// queues when a sequence is launched and are popped by a negedge monitor.
module tb_xadc_drp_reader;
    import xadc_drp_package::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xadc_drp_reader_if bus ();
    logic [15:0] dropped;
    logic        timeout_flag;
`ifdef XADC_DRP_READER_SEQ_TAG_EN
    logic [7:0]  seq;
`endif

    xadc_drp_reader #(
        .DRDY_TIMEOUT     (64),
        .DROP_COUNT_WIDTH (16)
    ) dut (
        .dclk_in           (clk),
        .reset_n_in        (rst_n),
        .drp               (bus.master),
        .dropped_count_out (dropped),
        .timeout_out       (timeout_flag)
`ifdef XADC_DRP_READER_SEQ_TAG_EN
        ,
        .sample_seq_out    (seq)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endfunction

    logic [31:0] exp_q[$];
    logic [6:0]  addr_q[$];

    // XADC responder
    bit          bfm_mute = 1'b0;
    logic [15:0] bfm_cur  = 16'h0;
    logic [15:0] bfm_volt = 16'h0;
    int          bfm_cnt  = 0;
    logic [6:0]  bfm_addr = 7'h0;

    always @(negedge clk) begin
        if (bfm_cnt == 1) begin
            bus.drdy_in = 1'b1;
            bus.do_in   = (bfm_addr == XADC_DRP_ADDR_CURRENT_CHANNEL) ? bfm_cur : bfm_volt;
            bfm_cnt     = 0;
        end else begin
            bus.drdy_in = 1'b0;
            bus.do_in   = 16'hDEAD;
            if (bfm_cnt > 1) bfm_cnt = bfm_cnt - 1;
        end
        if (bus.den_out && !bfm_mute) begin
            bfm_cnt  = 3;
            bfm_addr = bus.daddr_out;
        end
    end

    // Scoreboard monitor
    int den_seen = 0;
    int beats    = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.den_out) begin
                den_seen++;
                if (addr_q.size() == 0) fail_now("unexpected_den");
                else check("den_addr", 32'(bus.daddr_out), 32'(addr_q.pop_front()));
            end
            if (bus.sample_tvalid_out && bus.sample_tready_in) begin
                beats++;
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else check("beat_tdata", bus.sample_tdata_out, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [15:0] cur, input logic [15:0] volt,
                             input logic [31:0] exp, output int lat);
        bfm_cur  = cur;
        bfm_volt = volt;
        exp_q.push_back(exp);
        addr_q.push_back(XADC_DRP_ADDR_CURRENT_CHANNEL);
        addr_q.push_back(XADC_DRP_ADDR_VOLTAGE_CHANNEL);
        bus.eos_in = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
            bus.eos_in = 1'b0;
        end while (!bus.sample_tvalid_out && lat < 200);
        if (!bus.sample_tvalid_out) fail_now("seq_no_tvalid");
    endtask

    task automatic finish_beat();
        int n = 0;
        bus.sample_tready_in = 1'b1;
        while (bus.sample_tvalid_out && n < 50) begin
            step();
            n++;
        end
        if (bus.sample_tvalid_out) fail_now("beat_not_accepted");
    endtask

    typedef struct {
        logic [15:0] cur;
        logic [15:0] volt;
        int          hold;
        logic [31:0] exp_tdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat;
        int b0;
        int d0;
        int n;

        vecs[0] = '{16'h007F, 16'h00FF, 0,  32'h00FF_007F, 9};
        vecs[1] = '{16'h1234, 16'hABCD, 20, 32'hABCD_1234, 9};
        vecs[2] = '{16'hFFFF, 16'h0000, 3,  32'h0000_FFFF, 9};
        vecs[3] = '{16'h0000, 16'hFFFF, 1,  32'hFFFF_0000, 9};

        rst_n                = 1'b0;
        bus.eos_in           = 1'b0;
        bus.sample_tready_in = 1'b0;
        repeat (3) step();
        check("rst_den",     32'(bus.den_out),           32'h0);
        check("rst_dwe",     32'(bus.dwe_out),           32'h0);
        check("rst_di",      32'(bus.di_out),            32'h0);
        check("rst_daddr",   32'(bus.daddr_out),         32'h0);
        check("rst_tvalid",  32'(bus.sample_tvalid_out), 32'h0);
        check("rst_tdata",   bus.sample_tdata_out,       32'h0);
        check("rst_dropped", 32'(dropped),               32'h0);
        check("rst_timeout", 32'(timeout_flag),          32'h0);
        rst_n = 1'b1;
        step();

        // Table: latency, hold stability while ready is low, one beat each
        for (int i = 0; i < 4; i++) begin
            bus.sample_tready_in = (vecs[i].hold == 0);
            b0 = beats;
            start_seq(vecs[i].cur, vecs[i].volt, vecs[i].exp_tdata, lat);
            check("latency", 32'(lat), 32'(vecs[i].exp_lat));
            for (int k = 0; k < vecs[i].hold; k++) begin
                step();
                check("hold_tvalid", 32'(bus.sample_tvalid_out), 32'h1);
                check("hold_tdata",  bus.sample_tdata_out,       vecs[i].exp_tdata);
            end
            finish_beat();
            step();
            check("beat_count", 32'(beats), 32'(b0 + 1));
        end

        // EOS pulses while presenting are dropped
        bus.sample_tready_in = 1'b0;
        start_seq(16'h0123, 16'h0456, 32'h0456_0123, lat);
        repeat (3) begin
            bus.eos_in = 1'b1;
            step();
            bus.eos_in = 1'b0;
            step();
        end
        check("drop_count3",  32'(dropped),               32'd3);
        check("drop_tvalid",  32'(bus.sample_tvalid_out), 32'h1);
        check("drop_tdata",   bus.sample_tdata_out,       32'h0456_0123);
        // EOS coincident with the handshake is also dropped
        d0 = den_seen;
        bus.sample_tready_in = 1'b1;
        bus.eos_in           = 1'b1;
        step();
        bus.eos_in = 1'b0;
        check("drop_count4",   32'(dropped),               32'd4);
        check("hs_tvalid_low", 32'(bus.sample_tvalid_out), 32'h0);
        repeat (4) step();
        check("hs_no_den", 32'(den_seen), 32'(d0));
        start_seq(16'h0AAA, 16'h0555, 32'h0555_0AAA, lat);
        check("post_drop_latency", 32'(lat), 32'd9);
        finish_beat();
        step();

        // Responder silent: timeout at edge 64 after den, no beat
        bfm_mute = 1'b1;
        b0 = beats;
        d0 = den_seen;
        addr_q.push_back(XADC_DRP_ADDR_CURRENT_CHANNEL);
        bus.eos_in = 1'b1;
        step();
        bus.eos_in = 1'b0;
        check("to_den_pulse", 32'(bus.den_out), 32'h1);
        repeat (63) step();
        check("to_not_yet", 32'(timeout_flag), 32'h0);
        step();
        check("to_set",    32'(timeout_flag),          32'h1);
        check("to_tvalid", 32'(bus.sample_tvalid_out), 32'h0);
        repeat (5) step();
        check("to_no_beat", 32'(beats),    32'(b0));
        check("to_one_den", 32'(den_seen), 32'(d0 + 1));
        bfm_mute = 1'b0;
        start_seq(16'h0042, 16'h0777, 32'h0777_0042, lat);
        check("post_to_latency", 32'(lat), 32'd9);
        finish_beat();
        check("to_sticky", 32'(timeout_flag), 32'h1);
        step();

        // Reset while waiting for the voltage word
        bfm_cur  = 16'h1111;
        bfm_volt = 16'h2222;
        addr_q.push_back(XADC_DRP_ADDR_CURRENT_CHANNEL);
        addr_q.push_back(XADC_DRP_ADDR_VOLTAGE_CHANNEL);
        bus.eos_in = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            bus.eos_in = 1'b0;
        end while (!(bus.den_out && bus.daddr_out == XADC_DRP_ADDR_VOLTAGE_CHANNEL) && n < 50);
        if (n >= 50) fail_now("rst_seq_no_voltage_den");
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_den",     32'(bus.den_out),           32'h0);
        check("mid_rst_tvalid",  32'(bus.sample_tvalid_out), 32'h0);
        check("mid_rst_dropped", 32'(dropped),               32'h0);
        check("mid_rst_timeout", 32'(timeout_flag),          32'h0);
        check("mid_rst_daddr",   32'(bus.daddr_out),         32'h0);
        step();
        rst_n = 1'b1;
        d0 = den_seen;
        b0 = beats;
        repeat (6) step();
        check("late_drdy_no_den",    32'(den_seen),              32'(d0));
        check("late_drdy_no_beat",   32'(beats),                 32'(b0));
        check("late_drdy_no_tvalid", 32'(bus.sample_tvalid_out), 32'h0);
        bus.sample_tready_in = 1'b1;
        start_seq(16'h3333, 16'h4444, 32'h4444_3333, lat);
        check("post_rst_latency", 32'(lat), 32'd9);
        finish_beat();
        step();

`ifdef XADC_DRP_READER_SEQ_TAG_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.sample_tready_in = 1'b1;
        for (int i = 0; i < 257; i++) begin
            start_seq(16'(i), 16'(i + 7), {16'(i + 7), 16'(i)}, lat);
            check("seq_tag", 32'(seq), 32'(8'(i)));
            finish_beat();
        end
        step();
`endif

        check("addr_q_drained", 32'(addr_q.size()), 32'h0);
        check("exp_q_drained",  32'(exp_q.size()),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
